// File: rtl/exe_mul_seq_pkg.sv
// Shared definitions for the EXE-stage sequential multiplier.
//   mul_state_e   : multiplier FSM encoding (IDLE -> BUSY -> DONE -> IDLE)
//   MulWordLen    : default operand/result width
//   MulRegAddrLen : default register-file address width
package exe_mul_seq_pkg;

  localparam int unsigned MulWordLen    = 32;
  localparam int unsigned MulRegAddrLen = 5;

  typedef enum logic [1:0] {
    MulStIdle = 2'd0,
    MulStBusy = 2'd1,
    MulStDone = 2'd2
  } mul_state_e;

endpackage

// File: rtl/mul_shift_add_dp.sv
// Shift-add multiplier datapath: multiplicand (A), multiplier (B) and accumulator
// registers plus the logic for one iteration.
//   clk, rst   : clock, asynchronous active-high reset
//   load       : A <= val1, B <= val2, acc <= 0
//   step       : one iteration: acc += A if B[0]; A <<= 1; B >>= 1
//   val1, val2 : operands to load
//   acc        : current accumulator
//   acc_next   : accumulator value the current step would produce
module mul_shift_add_dp #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] val1,
  input  logic [WIDTH-1:0] val2,
  output logic [WIDTH-1:0] acc,
  output logic [WIDTH-1:0] acc_next
);

  logic [WIDTH-1:0] a_q, b_q, acc_q;

  // Carry out of the add is dropped: only the low WIDTH bits of the product matter.
  assign acc_next = b_q[0] ? (acc_q + a_q) : acc_q;
  assign acc      = acc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
    end else if (load) begin
      a_q   <= val1;
      b_q   <= val2;
      acc_q <= '0;
    end else if (step) begin
      a_q   <= a_q << 1;
      b_q   <= b_q >> 1;
      acc_q <= acc_next;
    end
  end

endmodule

// File: rtl/exe_mul_seq.sv
// EXE-stage sequential multiplier fed by the ID->EXE pipeline register.
// Takes WIDTH shift-add iterations per multiply and stalls upstream meanwhile.
//   clk, rst    : clock, asynchronous active-high reset
//   mul_en      : MUL enable from ID2EXE (held high while stalled)
//   val1, val2  : multiplicand / multiplier
//   dest_in     : destination register
//   wb_en_in    : write-back enable
//   flush       : synchronous abort, dominates mul_en
//   stall       : freeze IF/ID/ID2EXE
//   mul_valid   : one-cycle result pulse
//   mul_result  : low WIDTH bits of val1*val2
//   mul_dest    : destination captured at start
//   mul_wb_en   : captured write-back enable, gated by mul_valid
module exe_mul_seq
  import exe_mul_seq_pkg::*;
#(
  parameter int unsigned WIDTH  = MulWordLen,
  parameter int unsigned ADDR_W = MulRegAddrLen
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mul_en,
  input  logic [WIDTH-1:0]  val1,
  input  logic [WIDTH-1:0]  val2,
  input  logic [ADDR_W-1:0] dest_in,
  input  logic              wb_en_in,
  input  logic              flush,
  output logic              stall,
  output logic              mul_valid,
  output logic [WIDTH-1:0]  mul_result,
  output logic [ADDR_W-1:0] mul_dest,
  output logic              mul_wb_en
);

  localparam int unsigned      CNT_W   = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(WIDTH - 1);

  mul_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] dest_q;
  logic              wb_q;
  logic [WIDTH-1:0]  result_q;

  logic             dp_load, dp_step, res_load;
  logic [WIDTH-1:0] acc, acc_next;

  mul_shift_add_dp #(
    .WIDTH(WIDTH)
  ) u_dp (
    .clk      (clk),
    .rst      (rst),
    .load     (dp_load),
    .step     (dp_step),
    .val1     (val1),
    .val2     (val2),
    .acc      (acc),
    .acc_next (acc_next)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dp_load   = 1'b0;
    dp_step   = 1'b0;
    res_load  = 1'b0;
    mul_valid = 1'b0;
    unique case (state_q)
      MulStIdle: begin
        if (mul_en && !flush) begin
          dp_load = 1'b1;
          cnt_d   = '0;
          state_d = MulStBusy;
        end
      end
      MulStBusy: begin
        if (flush) begin
          state_d = MulStIdle;
        end else begin
          dp_step = 1'b1;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == CntLast) begin
            // Final step: latch the completed product so it holds after DONE.
            res_load = 1'b1;
            state_d  = MulStDone;
          end
        end
      end
      MulStDone: begin
        // mul_en still shows the finished instruction here, so it is ignored.
        mul_valid = !flush;
        state_d   = MulStIdle;
      end
      default: state_d = MulStIdle;
    endcase
  end

  // Reset is folded in so stall is low during reset even while mul_en is held.
  assign stall = !rst && (((state_q == MulStIdle) && mul_en && !flush) ||
                          (state_q == MulStBusy));

  assign mul_result = result_q;
  assign mul_dest   = dest_q;
  assign mul_wb_en  = mul_valid && wb_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= MulStIdle;
      cnt_q    <= '0;
      dest_q   <= '0;
      wb_q     <= 1'b0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (dp_load) begin
        dest_q <= dest_in;
        wb_q   <= wb_en_in;
      end
      if (res_load) begin
        result_q <= acc_next;
      end
    end
  end

endmodule

// File: tb/tb_exe_mul_seq.sv
module tb_exe_mul_seq;

  localparam int unsigned WIDTH   = 32;
  localparam int unsigned ADDR_W  = 5;
  localparam int unsigned LATENCY = WIDTH + 1;  // stall cycles per multiply

  logic              clk = 1'b0;
  logic              rst;
  logic              mul_en;
  logic [WIDTH-1:0]  val1, val2;
  logic [ADDR_W-1:0] dest_in;
  logic              wb_en_in;
  logic              flush;
  logic              stall;
  logic              mul_valid;
  logic [WIDTH-1:0]  mul_result;
  logic [ADDR_W-1:0] mul_dest;
  logic              mul_wb_en;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  exe_mul_seq #(
    .WIDTH  (WIDTH),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mul_en     (mul_en),
    .val1       (val1),
    .val2       (val2),
    .dest_in    (dest_in),
    .wb_en_in   (wb_en_in),
    .flush      (flush),
    .stall      (stall),
    .mul_valid  (mul_valid),
    .mul_result (mul_result),
    .mul_dest   (mul_dest),
    .mul_wb_en  (mul_wb_en)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: low WIDTH bits of the full product.
  function automatic logic [WIDTH-1:0] ref_mul(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    logic [2*WIDTH-1:0] p;
    p = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    return p[WIDTH-1:0];
  endfunction

  // Called just after a negedge while the DUT is idle. Drives one multiply, counts
  // stall cycles, checks the result cycle. With hold=1 it returns inside the result
  // cycle leaving mul_en high; otherwise it drops mul_en and checks the idle cycle.
  task automatic run_mul(input string tag, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input logic [ADDR_W-1:0] d,
                         input logic wb, input bit hold);
    int n;
    mul_en   = 1'b1;
    val1     = a;
    val2     = b;
    dest_in  = d;
    wb_en_in = wb;
    #1;
    n = 0;
    while (stall && n < 200) begin
      n++;
      @(negedge clk);
    end
    check({tag, ".stall_cycles"}, 32'(n), 32'(LATENCY));
    check({tag, ".valid"}, 32'(mul_valid), 32'd1);
    check({tag, ".result"}, mul_result, ref_mul(a, b));
    check({tag, ".dest"}, 32'(mul_dest), 32'(d));
    check({tag, ".wb_en"}, 32'(mul_wb_en), 32'(wb));
    if (!hold) begin
      mul_en = 1'b0;
      @(negedge clk);
      check({tag, ".valid_pulse"}, 32'(mul_valid), 32'd0);
      check({tag, ".wb_gated"}, 32'(mul_wb_en), 32'd0);
      check({tag, ".idle_stall"}, 32'(stall), 32'd0);
      check({tag, ".result_hold"}, mul_result, ref_mul(a, b));
    end
  endtask

  // Watches a window of cycles and returns how many carried mul_valid.
  task automatic count_valid(input int cycles, output int nv);
    nv = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (mul_valid) nv++;
    end
  endtask

  initial begin
    int nv;
    logic [WIDTH-1:0] ra, rb;

    rst = 1'b1; mul_en = 1'b0; val1 = '0; val2 = '0;
    dest_in = '0; wb_en_in = 1'b0; flush = 1'b0;
    #1;
    check("reset.stall", 32'(stall), 32'd0);
    check("reset.valid", 32'(mul_valid), 32'd0);
    check("reset.result", mul_result, 32'd0);
    check("reset.dest", 32'(mul_dest), 32'd0);
    check("reset.wb_en", 32'(mul_wb_en), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases
    run_mul("m7x6", 32'd7, 32'd6, 5'd3, 1'b1, 1'b0);
    run_mul("neg1x5", 32'hFFFF_FFFF, 32'd5, 5'd17, 1'b1, 1'b0);
    run_mul("ovf", 32'h0001_0000, 32'h0001_0000, 5'd31, 1'b0, 1'b0);
    run_mul("zero", 32'h1234_5678, 32'd0, 5'd9, 1'b1, 1'b0);

    // Back-to-back: next op appears in ID2EXE at the result edge
    run_mul("b2b_a", 32'd3, 32'd4, 5'd1, 1'b1, 1'b1);
    val1 = 32'd5; val2 = 32'd5; dest_in = 5'd2;
    @(negedge clk);
    check("b2b.gap_valid", 32'(mul_valid), 32'd0);
    check("b2b.gap_stall", 32'(stall), 32'd1);
    run_mul("b2b_b", 32'd5, 32'd5, 5'd2, 1'b1, 1'b0);

    // Flush in the 10th BUSY cycle
    mul_en = 1'b1; val1 = 32'd9; val2 = 32'd9; dest_in = 5'd4; wb_en_in = 1'b1;
    repeat (10) @(negedge clk);
    flush = 1'b1;
    #1;
    check("flush.busy_stall", 32'(stall), 32'd1);
    @(negedge clk);
    flush = 1'b0; mul_en = 1'b0;
    #1;
    check("flush.stall_drop", 32'(stall), 32'd0);
    count_valid(WIDTH + 8, nv);
    check("flush.no_valid", 32'(nv), 32'd0);
    run_mul("after_flush", 32'd2, 32'd3, 5'd6, 1'b1, 1'b0);

    // Asynchronous reset mid-BUSY, mul_en still asserted
    mul_en = 1'b1; val1 = 32'd11; val2 = 32'd13; dest_in = 5'd12; wb_en_in = 1'b1;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst.stall", 32'(stall), 32'd0);
    check("arst.valid", 32'(mul_valid), 32'd0);
    check("arst.result", mul_result, 32'd0);
    check("arst.dest", 32'(mul_dest), 32'd0);
    check("arst.wb_en", 32'(mul_wb_en), 32'd0);
    mul_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    count_valid(WIDTH + 8, nv);
    check("arst.no_result", 32'(nv), 32'd0);

    // Randomized operands against the reference product
    for (int i = 0; i < 20; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 5 == 0) rb = WIDTH'($urandom_range(0, 15));
      run_mul($sformatf("rand%0d", i), ra, rb, ADDR_W'($urandom_range(0, 31)),
              1'($urandom_range(0, 1)), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
